// File: rtl/mdu_pkg.sv
// Shared types and sizing for the iterative multiply/divide unit.
package mdu_pkg;

  localparam int unsigned MDU_WIDTH = 32;
  localparam int unsigned MDU_CNT_W = $clog2(MDU_WIDTH + 1);

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    MUL   = 2'b01,
    DIV   = 2'b10,
    FIXUP = 2'b11
  } mdu_state_e;

endpackage

// File: rtl/mdu_signfix.sv
// Restores signs on an unsigned {hi, lo} result: product, or remainder/quotient.
module mdu_signfix
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = MDU_WIDTH
) (
  input  mdu_op_e          op,
  input  logic             sign_a,
  input  logic             sign_b,
  input  logic             div_zero,
  input  logic [WIDTH-1:0] hi_in,
  input  logic [WIDTH-1:0] lo_in,
  output logic [WIDTH-1:0] hi_c,
  output logic [WIDTH-1:0] lo_c
);

  localparam int unsigned PW = 2 * WIDTH;

  logic [PW-1:0] prod_fix;
  logic          neg_prod;
  logic          neg_quo;
  logic          neg_rem;

  // A zero divisor leaves the all-ones quotient magnitude untouched.
  always_comb begin
    hi_c     = hi_in;
    lo_c     = lo_in;
    prod_fix = {hi_in, lo_in};
    neg_prod = (op == OP_MULT) && (sign_a ^ sign_b);
    neg_quo  = (op == OP_DIV) && (sign_a ^ sign_b) && !div_zero;
    neg_rem  = (op == OP_DIV) && sign_a;
    if (op == OP_DIV || op == OP_DIVU) begin
      hi_c = neg_rem ? (~hi_in + WIDTH'(1)) : hi_in;
      lo_c = neg_quo ? (~lo_in + WIDTH'(1)) : lo_in;
    end else begin
      if (neg_prod) prod_fix = ~{hi_in, lo_in} + PW'(1);
      hi_c = prod_fix[PW-1:WIDTH];
      lo_c = prod_fix[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/mdu_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and a hazard stall request.
module mdu_unit
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             StartE,
  input  logic [1:0]       OpE,
  input  logic             FlushE,
  input  logic [WIDTH-1:0] SrcAE,
  input  logic [WIDTH-1:0] SrcBE,
  input  logic             MtHiE,
  input  logic             MtLoE,
  input  logic             HiLoReadD,
  input  logic             MduOpD,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             Busy,
  output logic             Done,
  output logic             MduStall
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  mdu_state_e       state_q, state_d;
  mdu_op_e          op_q, op_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] opr_q, opr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sign_a_q, sign_a_d;
  logic             sign_b_q, sign_b_d;
  logic             div_zero_q, div_zero_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;

  logic             start_ok;
  logic             signed_in;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH:0]   mul_sum;
  logic [PW-1:0]    mul_next;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] div_diff;
  logic [PW-1:0]    div_next;
  logic [WIDTH-1:0] fix_hi;
  logic [WIDTH-1:0] fix_lo;
  logic             last_iter;

  assign start_ok  = StartE && !FlushE;
  assign signed_in = !OpE[0];
  assign mag_a     = (signed_in && SrcAE[WIDTH-1]) ? (~SrcAE + WIDTH'(1)) : SrcAE;
  assign mag_b     = (signed_in && SrcBE[WIDTH-1]) ? (~SrcBE + WIDTH'(1)) : SrcBE;
  assign last_iter = (cnt_q == CW'(WIDTH - 1));

  // Shift-add step: multiplier bits consumed from the bottom of acc.
  assign mul_sum  = {1'b0, acc_q[PW-1:WIDTH]} + {1'b0, opr_q};
  assign mul_next = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[PW-1:1]};

  // Restoring step: remainder in the top half, quotient bits enter at the bottom.
  assign rem_sh   = acc_q[PW-1:WIDTH-1];
  assign div_diff = rem_sh[WIDTH-1:0] - opr_q;
  assign div_next = (rem_sh >= {1'b0, opr_q})
                  ? {div_diff, acc_q[WIDTH-2:0], 1'b1}
                  : {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};

  mdu_signfix #(.WIDTH(WIDTH)) u_signfix (
    .op       (op_q),
    .sign_a   (sign_a_q),
    .sign_b   (sign_b_q),
    .div_zero (div_zero_q),
    .hi_in    (acc_q[PW-1:WIDTH]),
    .lo_in    (acc_q[WIDTH-1:0]),
    .hi_c     (fix_hi),
    .lo_c     (fix_lo)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      op_q       <= OP_MULT;
      acc_q      <= '0;
      opr_q      <= '0;
      cnt_q      <= '0;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      acc_q      <= acc_d;
      opr_q      <= opr_d;
      cnt_q      <= cnt_d;
      sign_a_q   <= sign_a_d;
      sign_b_q   <= sign_b_d;
      div_zero_q <= div_zero_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    acc_d      = acc_q;
    opr_d      = opr_q;
    cnt_d      = cnt_q;
    sign_a_d   = sign_a_q;
    sign_b_d   = sign_b_q;
    div_zero_d = div_zero_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_ok) begin
          op_d       = mdu_op_e'(OpE);
          sign_a_d   = signed_in && SrcAE[WIDTH-1];
          sign_b_d   = signed_in && SrcBE[WIDTH-1];
          div_zero_d = (SrcBE == '0);
          opr_d      = OpE[1] ? mag_b : mag_a;
          acc_d      = OpE[1] ? {WIDTH'(0), mag_a} : {WIDTH'(0), mag_b};
          cnt_d      = '0;
          state_d    = OpE[1] ? DIV : MUL;
        end else if (!FlushE) begin
          if (MtHiE) hi_d = SrcAE;
          if (MtLoE) lo_d = SrcAE;
        end
      end
      MUL: begin
        acc_d = mul_next;
        cnt_d = cnt_q + CW'(1);
        if (last_iter) state_d = FIXUP;
      end
      DIV: begin
        acc_d = div_next;
        cnt_d = cnt_q + CW'(1);
        if (last_iter) state_d = FIXUP;
      end
      FIXUP: begin
        hi_d    = fix_hi;
        lo_d    = fix_lo;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign Hi       = hi_q;
  assign Lo       = lo_q;
  assign Done     = done_q;
  assign Busy     = (state_q != IDLE);
  assign MduStall = Busy && (HiLoReadD || MduOpD);

endmodule
